uart_param_core: RTL

- Parametrised full-duplex UART core: serial transmitter plus receiver, with configurable data width, parity mode, stop-bit count and bit period.
- Successor to the fixed 8-bit UART block.
- Adds a valid/ready transmit handshake, a mid-bit sampling receiver with a 2-flop input synchroniser, and parity/framing error flags.
- Sits between byte-level logic and the pads; loopback benches tie TxLine to RxLine.

---
 rtl/uart_param_core.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_param_core.sv
// Parametrised full-duplex UART: valid/ready transmitter and mid-bit sampling receiver
// with a 2-flop input synchroniser and parity/framing error flags.
module uart_param_core #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 CLK,
  input  logic                 Reset,
  input  logic                 EN,
  input  logic [DATA_BITS-1:0] TxData,
  input  logic                 TxValid,
  output logic                 TxReady,
  output logic                 TxLine,
  output logic                 TxBusy,
  input  logic                 RxLine,
  output logic [DATA_BITS-1:0] RxData,
  output logic                 RxValid,
  output logic                 RxParityErr,
  output logic                 RxFrameErr
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LastCnt = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HalfCnt = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0] LastData = 4'(DATA_BITS - 1);
  localparam logic [3:0] LastStop = 4'(STOP_BITS - 1);
  localparam logic HasParity = (PARITY != 0);
  localparam logic OddParity = (PARITY == 2);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e                tx_state_q, tx_state_d, rx_state_q, rx_state_d;
  logic [CW-1:0]         tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [3:0]            tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0]  tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
  logic                  tx_par_q, tx_par_d, started_q;
  logic [1:0]            sync_q;
  logic                  rx_prev_q, rx_perr_q, rx_perr_d, rx_ferr_q, rx_ferr_d;
  logic [DATA_BITS-1:0]  rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d, rx_perr_out_q, rx_perr_out_d;
  logic                  rx_ferr_out_q, rx_ferr_out_d;
  logic                  tx_bit_end, rx_s, rx_fall, rx_sample, ferr_next;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      tx_state_q    <= StIdle;
      tx_cnt_q      <= '0;
      tx_bit_q      <= '0;
      tx_shift_q    <= '0;
      tx_par_q      <= 1'b0;
      started_q     <= 1'b0;
      sync_q        <= 2'b11;
      rx_prev_q     <= 1'b1;
      rx_state_q    <= StIdle;
      rx_cnt_q      <= '0;
      rx_bit_q      <= '0;
      rx_shift_q    <= '0;
      rx_perr_q     <= 1'b0;
      rx_ferr_q     <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      rx_perr_out_q <= 1'b0;
      rx_ferr_out_q <= 1'b0;
    end else begin
      tx_state_q    <= tx_state_d;
      tx_cnt_q      <= tx_cnt_d;
      tx_bit_q      <= tx_bit_d;
      tx_shift_q    <= tx_shift_d;
      tx_par_q      <= tx_par_d;
      started_q     <= 1'b1;
      sync_q        <= {sync_q[0], RxLine};
      rx_prev_q     <= rx_s;
      rx_state_q    <= rx_state_d;
      rx_cnt_q      <= rx_cnt_d;
      rx_bit_q      <= rx_bit_d;
      rx_shift_q    <= rx_shift_d;
      rx_perr_q     <= rx_perr_d;
      rx_ferr_q     <= rx_ferr_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      rx_perr_out_q <= rx_perr_out_d;
      rx_ferr_out_q <= rx_ferr_out_d;
    end
  end

  assign tx_bit_end = (tx_cnt_q == LastCnt);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    if (tx_state_q != StIdle) tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + CW'(1);
    unique case (tx_state_q)
      StIdle: if (TxValid && TxReady) begin
        tx_state_d = StStart;
        tx_shift_d = TxData;
        tx_par_d   = (^TxData) ^ OddParity;
        tx_cnt_d   = '0;
      end
      StStart: if (tx_bit_end) begin
        tx_state_d = StData;
        tx_bit_d   = '0;
      end
      StData: if (tx_bit_end) begin
        tx_shift_d = tx_shift_q >> 1;
        if (tx_bit_q == LastData) begin
          tx_state_d = HasParity ? StParity : StStop;
          tx_bit_d   = '0;
        end else begin
          tx_bit_d = tx_bit_q + 4'd1;
        end
      end
      StParity: if (tx_bit_end) begin
        tx_state_d = StStop;
        tx_bit_d   = '0;
      end
      StStop: if (tx_bit_end) begin
        if (tx_bit_q == LastStop) tx_state_d = StIdle;
        else tx_bit_d = tx_bit_q + 4'd1;
      end
      default: tx_state_d = StIdle;
    endcase
  end

  always_comb begin
    TxBusy  = (tx_state_q != StIdle);
    TxReady = started_q && (tx_state_q == StIdle) && EN;
    case (tx_state_q)
      StStart:  TxLine = 1'b0;
      StData:   TxLine = tx_shift_q[0];
      StParity: TxLine = tx_par_q;
      default:  TxLine = 1'b1;
    endcase
  end

  assign rx_s      = sync_q[1];
  // Edge-based start detect: a line stuck low after a bad stop bit cannot retrigger.
  assign rx_fall   = rx_prev_q & ~rx_s;
  assign rx_sample = (rx_state_q == StStart) ? (rx_cnt_q == HalfCnt) : (rx_cnt_q == LastCnt);
  assign ferr_next = rx_ferr_q | ~rx_s;

  always_comb begin
    rx_state_d    = rx_state_q;
    rx_cnt_d      = rx_cnt_q;
    rx_bit_d      = rx_bit_q;
    rx_shift_d    = rx_shift_q;
    rx_perr_d     = rx_perr_q;
    rx_ferr_d     = rx_ferr_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    rx_perr_out_d = rx_perr_out_q;
    rx_ferr_out_d = rx_ferr_out_q;
    if (rx_state_q != StIdle) rx_cnt_d = rx_sample ? '0 : rx_cnt_q + CW'(1);
    unique case (rx_state_q)
      StIdle: if (EN && rx_fall) begin
        rx_state_d = StStart;
        rx_cnt_d   = '0;
        rx_perr_d  = 1'b0;
        rx_ferr_d  = 1'b0;
      end
      StStart: if (rx_sample) begin
        rx_state_d = rx_s ? StIdle : StData;
        rx_bit_d   = '0;
      end
      StData: if (rx_sample) begin
        rx_shift_d = {rx_s, rx_shift_q[DATA_BITS-1:1]};
        if (rx_bit_q == LastData) begin
          rx_state_d = HasParity ? StParity : StStop;
          rx_bit_d   = '0;
        end else begin
          rx_bit_d = rx_bit_q + 4'd1;
        end
      end
      StParity: if (rx_sample) begin
        rx_perr_d  = rx_s != ((^rx_shift_q) ^ OddParity);
        rx_state_d = StStop;
      end
      StStop: if (rx_sample) begin
        rx_ferr_d = ferr_next;
        if (rx_bit_q == LastStop) begin
          rx_state_d    = StIdle;
          rx_valid_d    = 1'b1;
          rx_data_d     = rx_shift_q;
          rx_perr_out_d = rx_perr_q;
          rx_ferr_out_d = ferr_next;
        end else begin
          rx_bit_d = rx_bit_q + 4'd1;
        end
      end
      default: rx_state_d = StIdle;
    endcase
  end

  always_comb begin
    RxData      = rx_data_q;
    RxValid     = rx_valid_q;
    RxParityErr = rx_perr_out_q;
    RxFrameErr  = rx_ferr_out_q;
  end

endmodule
